// File: rtl/genaxis_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI-Stream egress between N generator sources.
// Optional per-source packet counters are added when GENAXIS_ARB_STATS_EN is defined.
module genaxis_rr_arbiter #(
    parameter int N  = 4,
    parameter int DW = 32,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]    s_tvalid,
    input  logic [N-1:0]    s_tlast,
    output logic [N-1:0]    s_tready,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tvalid,
    output logic            m_tlast,
    output logic [IW-1:0]   m_tid,
    input  logic            m_tready
`ifdef GENAXIS_ARB_STATS_EN
    ,
    output logic [N*32-1:0] pkt_cnt
`endif
);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e          state_q;
    logic [IW-1:0]   grant_q;
    logic [IW-1:0]   grant_d;
    logic [IW-1:0]   lastGrant_q;
    logic [N-1:0]    lastOnehot;
    logic [N-1:0]    thermo;
    logic [N-1:0]    mask;
    logic [N-1:0]    maskedReq;
    logic [N-1:0]    pickReq;
    logic            pktDone;

    // Prefer requesters strictly above the last winner; fall back to the lowest requester.
    always_comb begin
        lastOnehot              = '0;
        lastOnehot[lastGrant_q] = 1'b1;
        thermo                  = '0;
        thermo[0]               = lastOnehot[0];
        for (int i = 1; i < N; i++) begin
            thermo[i] = thermo[i-1] | lastOnehot[i];
        end
        mask      = thermo << 1;
        maskedReq = s_tvalid & mask;
        pickReq   = (|maskedReq) ? maskedReq : s_tvalid;
        grant_d   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pickReq[i]) begin
                grant_d = IW'(i);
            end
        end
    end

    always_comb begin
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        if (state_q == LOCK) begin
            m_tdata           = s_tdata[int'(grant_q)*DW +: DW];
            m_tvalid          = s_tvalid[grant_q];
            m_tlast           = s_tlast[grant_q];
            s_tready[grant_q] = m_tready;
        end
    end

    assign pktDone = (state_q == LOCK) && m_tvalid && m_tready && m_tlast;
    assign m_tid   = grant_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= IW'(N - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (|s_tvalid) begin
                        grant_q <= grant_d;
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if (pktDone) begin
                        lastGrant_q <= grant_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef GENAXIS_ARB_STATS_EN
    logic [31:0] pktCnt_q [N];

    // Counters wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                pktCnt_q[i] <= '0;
            end
        end else if (pktDone) begin
            pktCnt_q[grant_q] <= pktCnt_q[grant_q] + 32'd1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : gStats
        assign pkt_cnt[g*32 +: 32] = pktCnt_q[g];
    end
`endif

endmodule
